cisr_mult: RTL and testbench

//  Upstream neighbour of cisr_acc: per-channel multiply stage of the CISR SpMV datapath.

---
 rtl/cisr_mult_pkg.sv | 42 ++++
 rtl/cisr_mult_if.sv | 25 ++
 rtl/cisr_mult_lane.sv | 86 ++++++++
 rtl/cisr_mult.sv | 46 ++++
 tb/tb_cisr_mult.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cisr_mult_pkg.sv
// Shared widths, lane entry layout and product narrowing for the CISR multiply stage.
// Build option: CISR_MULT_SAT_EN selects saturating narrowing instead of two's-complement wrap.
package cisr_mult_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned VAL_W      = 16;
    localparam int unsigned COL_W      = 8;
    localparam int unsigned ENTRY_W    = COL_W + VAL_W;
    localparam int unsigned PROD_SHIFT = 0;
    localparam int unsigned OFIFO_D    = 4;
    localparam int unsigned PROD_W     = 2 * VAL_W;
    localparam int unsigned PTR_W      = $clog2(OFIFO_D);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned CREDIT_W   = CNT_W + 1;
    localparam int unsigned VMEM_D     = 2 ** COL_W;

    typedef struct packed {
        logic [COL_W-1:0]        col;
        logic signed [VAL_W-1:0] val;
    } entry_t;

    // Arithmetic shift, then either clamp to the VAL_W range or simply keep the low bits.
    function automatic logic [VAL_W-1:0] narrow_prod(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] r;
`ifdef CISR_MULT_SAT_EN
        logic signed [PROD_W-1:0] sat_max;
        logic signed [PROD_W-1:0] sat_min;
        sat_max = PROD_W'((2 ** (VAL_W - 1)) - 1);
        sat_min = -sat_max - PROD_W'(1);
        r = p >>> PROD_SHIFT;
        if (r > sat_max) begin
            r = sat_max;
        end else if (r < sat_min) begin
            r = sat_min;
        end
`else
        r = p >>> PROD_SHIFT;
`endif
        return r[VAL_W-1:0];
    endfunction

endpackage

// File: rtl/cisr_mult_if.sv
// Bus bundle between the multiply stage, its matrix FIFOs, the vector loader and cisr_acc.
interface cisr_mult_if;
    import cisr_mult_pkg::*;

    logic                        vec_we;
    logic [COL_W-1:0]            vec_addr;
    logic [VAL_W-1:0]            vec_data;
    logic [NUM_CH*ENTRY_W-1:0]   mat_fifo_data;
    logic [NUM_CH-1:0]           mat_fifo_empty;
    logic [NUM_CH-1:0]           mat_fifo_read;
    logic [NUM_CH*VAL_W-1:0]     mult_fifo_data;
    logic [NUM_CH-1:0]           mult_fifo_empty;
    logic [NUM_CH-1:0]           mult_fifo_read;

    modport master (
        output vec_we, vec_addr, vec_data, mat_fifo_data, mat_fifo_empty, mult_fifo_read,
        input  mat_fifo_read, mult_fifo_data, mult_fifo_empty
    );

    modport slave (
        input  vec_we, vec_addr, vec_data, mat_fifo_data, mat_fifo_empty, mult_fifo_read,
        output mat_fifo_read, mult_fifo_data, mult_fifo_empty
    );

endinterface

// File: rtl/cisr_mult_lane.sv
// One multiply lane: credit-gated issue, capture/lookup/multiply pipe, FWFT product FIFO.
// Narrowing follows CISR_MULT_SAT_EN through narrow_prod().
module cisr_mult_lane
    import cisr_mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  entry_t                  entry_i,
    input  logic                    empty_i,
    output logic                    read_o,
    output logic [COL_W-1:0]        lookup_col_o,
    input  logic signed [VAL_W-1:0] lookup_x_i,
    output logic [VAL_W-1:0]        data_o,
    output logic                    empty_o,
    input  logic                    pop_i
);

    logic                     s0_v_q;
    entry_t                   s0_q;
    logic                     s1_v_q;
    logic signed [VAL_W-1:0]  s1_val_q;
    logic signed [VAL_W-1:0]  s1_x_q;
    logic [VAL_W-1:0]         mem_q [OFIFO_D];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     pop;
    logic                     push;
    logic [CREDIT_W-1:0]      credit;
    logic signed [PROD_W-1:0] prod;
    logic [VAL_W-1:0]         narrow;

    // A pop in the same cycle frees a slot, so full FIFOs still sustain one issue per cycle.
    always_comb begin
        pop    = pop_i && (cnt_q != '0);
        push   = s1_v_q;
        credit = CREDIT_W'(cnt_q) + CREDIT_W'(s0_v_q) + CREDIT_W'(s1_v_q) - CREDIT_W'(pop);
        read_o = !rst && !empty_i && (credit < CREDIT_W'(OFIFO_D));
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        prod   = PROD_W'(s1_val_q) * PROD_W'(s1_x_q);
        narrow = narrow_prod(prod);
    end

    assign lookup_col_o = s0_q.col;
    assign empty_o      = (cnt_q == '0);
    assign data_o       = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v_q   <= 1'b0;
            s0_q     <= '0;
            s1_v_q   <= 1'b0;
            s1_val_q <= '0;
            s1_x_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            s0_v_q <= read_o;
            if (read_o) begin
                s0_q <= entry_i;
            end
            s1_v_q <= s0_v_q;
            if (s0_v_q) begin
                s1_val_q <= s0_q.val;
                s1_x_q   <= lookup_x_i;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= narrow;
        end
    end

endmodule

// File: rtl/cisr_mult.sv
// CISR SpMV multiply stage: shared vector memory feeding NUM_CH independent multiply lanes.
// Build option: CISR_MULT_SAT_EN (saturating product narrowing).
module cisr_mult
    import cisr_mult_pkg::*;
(
    input logic        clk,
    input logic        rst,
    cisr_mult_if.slave bus
);

    logic signed [VAL_W-1:0] vmem_q [VMEM_D];
    logic [COL_W-1:0]        lookup_col [NUM_CH];
    logic signed [VAL_W-1:0] lookup_x   [NUM_CH];
    logic [NUM_CH-1:0]       read_c;
    logic [NUM_CH-1:0]       empty_c;
    logic [VAL_W-1:0]        data_c     [NUM_CH];

    // Async reads see the pre-write value when a write hits the same address this cycle.
    always_ff @(posedge clk) begin
        if (bus.vec_we) begin
            vmem_q[bus.vec_addr] <= bus.vec_data;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign lookup_x[i] = vmem_q[lookup_col[i]];
        assign bus.mult_fifo_data[i*VAL_W +: VAL_W] = data_c[i];

        cisr_mult_lane u_lane (
            .clk          (clk),
            .rst          (rst),
            .entry_i      (bus.mat_fifo_data[i*ENTRY_W +: ENTRY_W]),
            .empty_i      (bus.mat_fifo_empty[i]),
            .read_o       (read_c[i]),
            .lookup_col_o (lookup_col[i]),
            .lookup_x_i   (lookup_x[i]),
            .data_o       (data_c[i]),
            .empty_o      (empty_c[i]),
            .pop_i        (bus.mult_fifo_read[i])
        );
    end

    assign bus.mat_fifo_read   = read_c;
    assign bus.mult_fifo_empty = empty_c;

endmodule

// File: tb/tb_cisr_mult.sv
// Directed bench for cisr_mult: vector table plus latency, credit, throughput, reset and
// vector-memory write-collision sequences.
module tb_cisr_mult;
    import cisr_mult_pkg::*;

    typedef struct {
        int    lane;
        int    col;
        int    x;
        int    val;
        int    exp_wrap;
        int    exp_sat;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    cisr_mult_if mif ();

    cisr_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    int               nread [NUM_CH];
    entry_t           inq   [NUM_CH][$];
    logic [VAL_W-1:0] outq  [NUM_CH][$];
    vec_t             vt    [7];

    function automatic logic [VAL_W-1:0] lane_data(input int lane);
        return mif.mult_fifo_data[lane*VAL_W +: VAL_W];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_mat();
        for (int i = 0; i < NUM_CH; i++) begin
            if (inq[i].size() > 0) begin
                mif.mat_fifo_empty[i] = 1'b0;
                mif.mat_fifo_data[i*ENTRY_W +: ENTRY_W] = inq[i][0];
            end else begin
                mif.mat_fifo_empty[i] = 1'b1;
                mif.mat_fifo_data[i*ENTRY_W +: ENTRY_W] = '0;
            end
        end
    endtask

    // Sample at the falling edge, then update the upstream FIFO model just after the rising edge.
    task automatic tick();
        logic [NUM_CH-1:0] snap;
        @(negedge clk);
        snap = mif.mat_fifo_read;
        for (int i = 0; i < NUM_CH; i++) begin
            if (snap[i]) nread[i]++;
            if (mif.mult_fifo_read[i] && !mif.mult_fifo_empty[i]) outq[i].push_back(lane_data(i));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (snap[i] && inq[i].size() > 0) void'(inq[i].pop_front());
        end
        drive_mat();
    endtask

    task automatic push(input int lane, input int col, input int val);
        entry_t e;
        e.col = COL_W'(col);
        e.val = VAL_W'(val);
        inq[lane].push_back(e);
        drive_mat();
    endtask

    task automatic vec_write(input int addr, input int d);
        mif.vec_we   = 1'b1;
        mif.vec_addr = COL_W'(addr);
        mif.vec_data = VAL_W'(d);
        tick();
        mif.vec_we   = 1'b0;
    endtask

    task automatic expect_head(input int lane, input int exp, input string nm);
        int k = 0;
        while (mif.mult_fifo_empty[lane] && k < 12) begin
            tick();
            k++;
        end
        if (mif.mult_fifo_empty[lane]) begin
            total++;
            bad++;
            $display("FAIL %s: head still empty after %0d cycles, want 0x%0h", nm, k, exp);
        end else begin
            check(nm, 32'(lane_data(lane)), 32'(exp));
            mif.mult_fifo_read[lane] = 1'b1;
            tick();
            mif.mult_fifo_read[lane] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        int e;
        int n0;

        vt[0] = '{0,   5,     3,     46, 'h008A, 'h008A, "v_46x3"};
        vt[1] = '{1,   9,   554,   -193, 'h5E56, 'h8000, "v_neg193x554"};
        vt[2] = '{2,   0,    -7,     -9, 'h003F, 'h003F, "v_neg9xneg7"};
        vt[3] = '{3, 255, 32767,  32767, 'h0001, 'h7FFF, "v_maxxmax"};
        vt[4] = '{0,  17,    -1, -32768, 'h8000, 'h7FFF, "v_minxneg1"};
        vt[5] = '{1, 100,   200,   -100, 'hB1E0, 'hB1E0, "v_neg100x200"};
        vt[6] = '{2,   3,     0,   1234, 'h0000, 'h0000, "v_zero"};

        for (int i = 0; i < NUM_CH; i++) nread[i] = 0;
        rst                = 1'b1;
        mif.vec_we         = 1'b0;
        mif.vec_addr       = '0;
        mif.vec_data       = '0;
        mif.mult_fifo_read = '0;
        drive_mat();
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", 32'(mif.mult_fifo_empty), 32'hF);
        check("rst_read",  32'(mif.mat_fifo_read), 32'h0);
        check("rst_data",  32'(mif.mult_fifo_data), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_empty", 32'(mif.mult_fifo_empty), 32'hF);

        // Table of single products across lanes and sign/range corners.
        for (int v = 0; v < 7; v++) begin
`ifdef CISR_MULT_SAT_EN
            e = vt[v].exp_sat;
`else
            e = vt[v].exp_wrap;
`endif
            vec_write(vt[v].col, vt[v].x);
            push(vt[v].lane, vt[v].col, vt[v].val);
            expect_head(vt[v].lane, e, vt[v].name);
        end
        check("tbl_drained", 32'(mif.mult_fifo_empty), 32'hF);

        // Issue-to-visible latency: read in cycle N, empty falls at N+3.
        n0 = nread[0];
        push(0, 5, 46);
        tick();
        check("lat_read_pulses", 32'(nread[0] - n0), 32'd1);
        check("lat_empty_n1", 32'(mif.mult_fifo_empty[0]), 32'd1);
        tick();
        check("lat_empty_n2", 32'(mif.mult_fifo_empty[0]), 32'd1);
        tick();
        check("lat_empty_n3", 32'(mif.mult_fifo_empty[0]), 32'd0);
        expect_head(0, 138, "lat_data");

        // Credit limit: no pops, six offered, exactly OFIFO_D issued; one pop frees exactly one.
        n0 = nread[2];
        outq[2].delete();
        for (int k = 1; k <= 6; k++) push(2, 5, k);
        repeat (12) tick();
        check("cred_issued", 32'(nread[2] - n0), 32'd4);
        mif.mult_fifo_read[2] = 1'b1;
        tick();
        mif.mult_fifo_read[2] = 1'b0;
        check("cred_pop_cnt", 32'(outq[2].size()), 32'd1);
        check("cred_pop_val", (outq[2].size() > 0) ? 32'(outq[2][0]) : 32'hDEAD, 32'd3);
        repeat (8) tick();
        check("cred_one_more", 32'(nread[2] - n0), 32'd5);
        for (int k = 2; k <= 6; k++) expect_head(2, 3 * k, $sformatf("cred_drain%0d", k));

        // Sustained throughput from a full FIFO with continuous pops.
        outq[3].delete();
        for (int k = 1; k <= 32; k++) push(3, 5, k);
        repeat (10) tick();
        check("thr_full", 32'(mif.mult_fifo_empty[3]), 32'd0);
        mif.mult_fifo_read[3] = 1'b1;
        repeat (32) tick();
        mif.mult_fifo_read[3] = 1'b0;
        check("thr_count", 32'(outq[3].size()), 32'd32);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("thr_item%0d", k),
                  (k < outq[3].size()) ? 32'(outq[3][k]) : 32'hDEAD, 32'(3 * (k + 1)));
        end
        tick();
        check("thr_empty_after", 32'(mif.mult_fifo_empty[3]), 32'd1);

        // Reset with products in flight and upstream still holding data.
        push(0, 5, 1);
        push(0, 5, 2);
        push(0, 5, 3);
        push(1, 5, 4);
        push(2, 5, 5);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_read",  32'(mif.mat_fifo_read), 32'h0);
        check("mrst_empty", 32'(mif.mult_fifo_empty), 32'hF);
        for (int i = 0; i < NUM_CH; i++) inq[i].delete();
        drive_mat();
        tick();
        tick();
        rst = 1'b0;
        tick();
        push(0, 5, 10);
        expect_head(0, 30, "mrst_post_item");
        repeat (4) tick();
        check("mrst_no_stale", 32'(mif.mult_fifo_empty), 32'hF);

        // Vector write colliding with a lookup of the same address returns the old value.
        push(3, 5, 11);
        tick();
        mif.vec_we   = 1'b1;
        mif.vec_addr = COL_W'(5);
        mif.vec_data = VAL_W'(7);
        push(3, 5, 11);
        tick();
        mif.vec_we   = 1'b0;
        expect_head(3, 33, "wcol_old_val");
        expect_head(3, 77, "wcol_new_val");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
